// File: rtl/fetch_prefetch_queue.sv
// Decoupled instruction-fetch stage. Owns the PC, issues one request per cycle to a
// 1-cycle-latency IMEM and buffers {pc, instr} pairs in a small FIFO for decode.
// A redirect flushes buffered and in-flight fetches and restarts at the target.
module fetch_prefetch_queue #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       PCWrite_F,
    input  logic [XLEN-1:0]            PCTarget,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [ILEN-1:0]            imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [ILEN-1:0]            out_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned CRW = CW + 1;
    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [PW-1:0] ptr_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q;
    logic [XLEN-1:0] inflight_pc_q;
    logic [XLEN-1:0] fifo_pc_q    [DEPTH];
    logic [ILEN-1:0] fifo_instr_q [DEPTH];
    ptr_t            rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q;

    logic            pop;
    logic            push;
    logic [CRW-1:0]  credits;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Handshake, credit check, output muxing and next fetch PC.
    always_comb begin
        out_valid = ~rst & (count_q != '0);
        pop       = out_valid & out_ready & ~PCWrite_F;
        push      = inflight_q & ~rst & ~PCWrite_F;
        // Occupancy after this cycle's pop plus the response still owed; never exceeds DEPTH.
        credits   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
        imem_req  = ~rst & ~PCWrite_F & (credits < CRW'(DEPTH));
        imem_addr = fetch_pc_q;
        count     = rst ? '0 : count_q;
        out_pc    = out_valid ? fifo_pc_q[rd_ptr_q] : '0;
        out_instr = out_valid ? fifo_instr_q[rd_ptr_q] : '0;

        fetch_pc_d = fetch_pc_q;
        if (PCWrite_F) begin
            fetch_pc_d = {PCTarget[XLEN-1:2], 2'b00};
        end else if (imem_req) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
    end

    // PC, in-flight tracking and FIFO control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= imem_req;
            inflight_pc_q <= imem_addr;
            if (PCWrite_F) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // FIFO storage; contents need no reset because count_q qualifies them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: directed vector table, hand-written
// corner sequences and a randomized run, all compared against a queue-based model.
module tb_fetch_prefetch_queue;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned ILEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned CW       = $clog2(DEPTH + 1);
    localparam logic [63:0] RESET_PC = 64'h0;

    logic            clk;
    logic            rst;
    logic            PCWrite_F;
    logic [XLEN-1:0] PCTarget;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_instr;
    logic [CW-1:0]   count;

    fetch_prefetch_queue #(
        .XLEN    (XLEN),
        .ILEN    (ILEN),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .PCWrite_F (PCWrite_F),
        .PCTarget  (PCTarget),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instruction memory contents.
    function automatic logic [31:0] imem_word(input logic [63:0] a);
        logic [63:0] idx;
        idx = a >> 2;
        case (idx)
            64'd0:   return 32'h0000_0013;
            64'd1:   return 32'h0050_0093;
            64'd2:   return 32'h0000_0013;
            64'd10:  return 32'hDEAD_BEEF;
            default: return idx[31:0] ^ 32'hA5A5_0003;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected instruction stream as a queue of {pc, instr}.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        m_q[$];
    logic [63:0] m_pc     = RESET_PC;
    logic        m_fly    = 1'b0;
    logic [63:0] m_fly_pc = 64'h0;

    // Outputs sampled in the last step.
    logic        s_req;
    logic [63:0] s_addr;
    logic        s_valid;
    logic [63:0] s_pc;
    logic [31:0] s_instr;
    logic [CW-1:0] s_count;

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model, answer IMEM.
    task automatic step(input logic r, input logic pw, input logic [63:0] tgt, input logic rdy);
        logic        e_valid;
        logic        e_pop;
        logic        e_req;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        int          e_cnt;
        ent_t        e;
        rst       = r;
        PCWrite_F = pw;
        PCTarget  = tgt;
        out_ready = rdy;
        @(negedge clk);
        e_valid = !r && (m_q.size() > 0);
        e_pc    = e_valid ? m_q[0].pc : 64'h0;
        e_instr = e_valid ? m_q[0].instr : 32'h0;
        e_cnt   = r ? 0 : m_q.size();
        e_pop   = e_valid && rdy && !pw;
        e_req   = !r && !pw && ((m_q.size() + int'(m_fly) - int'(e_pop)) < int'(DEPTH));
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = out_valid;
        s_pc    = out_pc;
        s_instr = out_instr;
        s_count = count;
        chk("imem_req", s_req, e_req);
        if (e_req) chk("imem_addr", s_addr, m_pc);
        chk("out_valid", s_valid, e_valid);
        chk("out_pc", s_pc, e_pc);
        chk("out_instr", s_instr, e_instr);
        chk("count", s_count, e_cnt);
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_fly = 1'b0;
            m_pc  = RESET_PC;
        end else if (pw) begin
            m_q.delete();
            m_fly = 1'b0;
            m_pc  = tgt & ~64'd3;
        end else begin
            if (e_pop) void'(m_q.pop_front());
            if (m_fly) begin
                e.pc    = m_fly_pc;
                e.instr = imem_word(m_fly_pc);
                m_q.push_back(e);
            end
            m_fly    = e_req;
            m_fly_pc = m_pc;
            if (e_req) m_pc = m_pc + 64'd4;
        end
        #1;
        imem_rdata = s_req ? imem_word(s_addr) : $urandom();
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 64'h0, rdy);
    endtask

    typedef struct {
        logic        rst;
        logic        pw;
        logic [63:0] tgt;
        logic        rdy;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_valid;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t vecs[6];
    int   nreq;

    initial begin
        rst        = 1'b1;
        PCWrite_F  = 1'b0;
        PCTarget   = '0;
        out_ready  = 1'b0;
        imem_rdata = '0;

        // Reset then streaming fetch with out_ready=1.
        vecs[0] = '{1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0,  1'b0, 64'h0, 32'h0,         3'd0};
        vecs[1] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'h0,  1'b0, 64'h0, 32'h0,         3'd0};
        vecs[2] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'h4,  1'b0, 64'h0, 32'h0,         3'd0};
        vecs[3] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'h8,  1'b1, 64'h0, 32'h0000_0013, 3'd1};
        vecs[4] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'hC,  1'b1, 64'h4, 32'h0050_0093, 3'd1};
        vecs[5] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'h10, 1'b1, 64'h8, 32'h0000_0013, 3'd1};
        for (int i = 0; i < 6; i++) begin
            step(vecs[i].rst, vecs[i].pw, vecs[i].tgt, vecs[i].rdy);
            chk("vec_req", s_req, vecs[i].e_req);
            if (vecs[i].e_req) chk("vec_addr", s_addr, vecs[i].e_addr);
            chk("vec_valid", s_valid, vecs[i].e_valid);
            chk("vec_pc", s_pc, vecs[i].e_pc);
            chk("vec_instr", s_instr, vecs[i].e_instr);
            chk("vec_count", s_count, vecs[i].e_cnt);
        end

        // Backpressure: requests stop at DEPTH, head held, then gapless release.
        step(1'b1, 1'b0, 64'h0, 1'b0);
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 64'h0, 1'b0);
            nreq += int'(s_req);
        end
        chk("bp_nreq", nreq, DEPTH);
        chk("bp_count", s_count, DEPTH);
        chk("bp_valid", s_valid, 1'b1);
        chk("bp_hold_pc", s_pc, 64'h0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 64'h0, 1'b1);
            chk("bp_release_valid", s_valid, 1'b1);
            chk("bp_release_pc", s_pc, 64'(4 * i));
        end

        // Redirect while streaming.
        step(1'b1, 1'b0, 64'h0, 1'b1);
        run(6, 1'b1);
        step(1'b0, 1'b1, 64'd40, 1'b1);
        chk("redir_req_T", s_req, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("redir_count_T1", s_count, 0);
        chk("redir_valid_T1", s_valid, 1'b0);
        chk("redir_addr_T1", s_addr, 64'h28);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("redir_valid_T2", s_valid, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("redir_valid_T3", s_valid, 1'b1);
        chk("redir_pc_T3", s_pc, 64'h28);
        chk("redir_instr_T3", s_instr, 32'hDEAD_BEEF);

        // Misaligned target, then back-to-back redirects.
        step(1'b0, 1'b1, 64'h2A, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("align_req", s_req, 1'b1);
        chk("align_addr", s_addr, 64'h28);
        step(1'b0, 1'b1, 64'h100, 1'b1);
        step(1'b0, 1'b1, 64'h200, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("b2b_addr_T1", s_addr, 64'h200);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("b2b_valid_T2", s_valid, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("b2b_pc_T3", s_pc, 64'h200);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("b2b_pc_T4", s_pc, 64'h204);

        // PC wrap at the top of the address space.
        step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        run(3, 1'b1);
        chk("wrap_pc_top", s_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("wrap_pc_zero", s_pc, 64'h0);

        // Reset mid-operation with entries buffered and a fetch in flight.
        step(1'b1, 1'b0, 64'h0, 1'b0);
        run(4, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        chk("rst_pre_count", s_count, 3);
        step(1'b1, 1'b0, 64'h0, 1'b0);
        chk("rst_req", s_req, 1'b0);
        chk("rst_valid", s_valid, 1'b0);
        chk("rst_count", s_count, 0);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("rst_c0_addr", s_addr, RESET_PC);
        chk("rst_c0_valid", s_valid, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("rst_c1_valid", s_valid, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("rst_c2_valid", s_valid, 1'b1);
        chk("rst_c2_pc", s_pc, RESET_PC);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        pw;
            logic        rdy;
            logic [63:0] tgt;
            r   = ($urandom_range(0, 199) == 0);
            pw  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            else                           tgt = {$urandom(), $urandom()};
            step(r, pw, tgt, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
